priv_1_11_trap_sequencer: RTL

- Machine-mode trap controller for the priv 1.11 CSR block.
- Arbitrates simultaneous exception causes and pending, enabled interrupts into a single trap.
- Sequences the CSR updates for trap entry (mepc/mcause/mtval, then the mstatus push) and MRET (mstatus pop), then hands a redirect PC to fetch under a valid/ack handshake.
- Sits between the execute/commit stage and the CSR register file.

---
 rtl/machine_mode_types_1_11.sv | 36 +++
 rtl/trap_priority_encoder.sv | 44 ++++
 rtl/priv_1_11_trap_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/machine_mode_types_1_11.sv
// Shared machine-mode types for the priv 1.11 CSR block: trap sequencer states,
// mstatus update opcodes and the fixed trap cause priority orders.
package machine_mode_types_1_11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAVE,
      ST_STACK,
      ST_RESTORE,
      ST_REDIRECT
   } trap_state_t;

   typedef enum logic [1:0] {
      MSTATUS_NONE = 2'd0,
      MSTATUS_PUSH = 2'd1,
      MSTATUS_POP  = 2'd2
   } mstatus_op_t;

   // Highest priority first; exception codes 10 and 14 are reserved and never selected.
   localparam int EXC_PRIO_N = 14;
   localparam logic [3:0] EXC_PRIO [EXC_PRIO_N] = '{
      4'd3, 4'd12, 4'd1, 4'd2, 4'd0, 4'd8, 4'd9,
      4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5
   };

   localparam int IRQ_PRIO_N = 9;
   localparam logic [3:0] IRQ_PRIO [IRQ_PRIO_N] = '{
      4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5, 4'd8, 4'd0, 4'd4
   };

   // Machine, supervisor and user software/timer/external interrupt bits.
   localparam logic [31:0] IRQ_MASK = 32'h0000_0BBB;

   localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

endpackage

// File: rtl/trap_priority_encoder.sv
// Fixed-priority cause selection for exception and interrupt request vectors.
// Kept standalone so the supervisor delegation logic can share it.
module trap_priority_encoder
   import machine_mode_types_1_11::*;
#(
   parameter int EXC_W = 16
) (
   input  logic [EXC_W-1:0] i_exc_vec,
   input  logic [11:0]      i_irq_vec,
   output logic             o_exc_valid,
   output logic [3:0]       o_exc_cause,
   output logic             o_irq_valid,
   output logic [3:0]       o_irq_cause
);

   logic w_unused;

   assign w_unused = ^{i_irq_vec[2], i_irq_vec[6], i_irq_vec[10]};

   // Scan lowest priority first so the highest-priority hit is the last write.
   // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
   always_comb begin
      o_exc_valid = 1'b0;
      o_exc_cause = '0;
      for (int i = EXC_PRIO_N - 1; i >= 0; i--) begin
         if ((int'(EXC_PRIO[i]) < EXC_W) && i_exc_vec[EXC_PRIO[i]]) begin
            o_exc_valid = 1'b1;
            o_exc_cause = EXC_PRIO[i];
         end
      end
   end

   always_comb begin
      o_irq_valid = 1'b0;
      o_irq_cause = '0;
      for (int i = IRQ_PRIO_N - 1; i >= 0; i--) begin
         if (i_irq_vec[IRQ_PRIO[i]]) begin
            o_irq_valid = 1'b1;
            o_irq_cause = IRQ_PRIO[i];
         end
      end
   end

endmodule

// File: rtl/priv_1_11_trap_sequencer.sv
// Machine-mode trap sequencer: accepts one exception, MRET or interrupt, writes
// mepc/mcause/mtval, updates mstatus, then hands a redirect PC to fetch.
module priv_1_11_trap_sequencer
   import machine_mode_types_1_11::*;
#(
   parameter bit VECTORED_EN = 1'b1,
   parameter int EXC_W       = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic [EXC_W-1:0] exc_req,
   input  logic [31:0]      exc_pc,
   input  logic [31:0]      exc_tval,
   input  logic             mret_req,
   input  logic [31:0]      mip,
   input  logic [31:0]      mie,
   input  logic             mstatus_mie,
   input  logic [31:0]      mtvec,
   input  logic [31:0]      mepc,
   output logic             trap_busy,
   output logic             pipe_flush,
   output logic             mepc_we,
   output logic             mcause_we,
   output logic             mtval_we,
   output logic [31:0]      mepc_wdata,
   output logic [31:0]      mcause_wdata,
   output logic [31:0]      mtval_wdata,
   output logic [1:0]       mstatus_op,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   input  logic             redirect_ack
);

   trap_state_t r_state;
   logic        r_intr;
   logic [3:0]  r_cause;
   logic [31:2] r_pc;
   logic [31:0] r_tval;
   logic [31:0] r_redirect_pc;

   logic        w_exc_valid;
   logic [3:0]  w_exc_cause;
   logic        w_irq_valid;
   logic [3:0]  w_irq_cause;
   logic [11:0] w_irq_pend;
   logic        w_take_irq;
   logic [31:0] w_trap_base;
   logic [31:0] w_trap_target;
   mstatus_op_t w_mstatus_op;
   logic        w_unused;

   assign w_unused   = ^{mip[31:12], mie[31:12], exc_pc[1:0], mepc[1:0]};
   assign w_irq_pend = mip[11:0] & mie[11:0] & IRQ_MASK[11:0];
   assign w_take_irq = mstatus_mie & w_irq_valid;

   trap_priority_encoder #(
      .EXC_W (EXC_W)
   ) u_prio (
      .i_exc_vec   (exc_req),
      .i_irq_vec   (w_irq_pend),
      .o_exc_valid (w_exc_valid),
      .o_exc_cause (w_exc_cause),
      .o_irq_valid (w_irq_valid),
      .o_irq_cause (w_irq_cause)
   );

   // Vectored dispatch applies only to interrupts; exceptions always use the base.
   assign w_trap_base   = {mtvec[31:2], 2'b00};
   assign w_trap_target = (VECTORED_EN && (mtvec[1:0] == MTVEC_MODE_VECTORED) && r_intr)
                        ? w_trap_base + {26'd0, r_cause, 2'b00}
                        : w_trap_base;

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state       <= ST_IDLE;
         r_intr        <= 1'b0;
         r_cause       <= '0;
         r_pc          <= '0;
         r_tval        <= '0;
         r_redirect_pc <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_exc_valid) begin
                  r_state <= ST_SAVE;
                  r_intr  <= 1'b0;
                  r_cause <= w_exc_cause;
                  r_pc    <= exc_pc[31:2];
                  r_tval  <= exc_tval;
               end else if (mret_req) begin
                  r_state <= ST_RESTORE;
               end else if (w_take_irq) begin
                  r_state <= ST_SAVE;
                  r_intr  <= 1'b1;
                  r_cause <= w_irq_cause;
                  r_pc    <= exc_pc[31:2];
                  r_tval  <= '0;
               end
            end
            ST_SAVE: r_state <= ST_STACK;
            ST_STACK: begin
               r_redirect_pc <= w_trap_target;
               r_state       <= ST_REDIRECT;
            end
            ST_RESTORE: begin
               r_redirect_pc <= {mepc[31:2], 2'b00};
               r_state       <= ST_REDIRECT;
            end
            ST_REDIRECT: begin
               if (redirect_ack) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_mstatus_op = MSTATUS_NONE;
      case (r_state)
         ST_STACK:   w_mstatus_op = MSTATUS_PUSH;
         ST_RESTORE: w_mstatus_op = MSTATUS_POP;
         default:    w_mstatus_op = MSTATUS_NONE;
      endcase
   end

   // Flush is the only input-dependent output: it marks the acceptance cycle itself.
   assign pipe_flush     = nRST && (r_state == ST_IDLE) && (w_exc_valid || mret_req || w_take_irq);
   assign trap_busy      = (r_state != ST_IDLE);
   assign mepc_we        = (r_state == ST_SAVE);
   assign mcause_we      = (r_state == ST_SAVE);
   assign mtval_we       = (r_state == ST_SAVE);
   assign mstatus_op     = w_mstatus_op;
   assign redirect_valid = (r_state == ST_REDIRECT);
   assign redirect_pc    = r_redirect_pc;
   assign mepc_wdata     = {r_pc, 2'b00};
   assign mcause_wdata   = {r_intr, 27'd0, r_cause};
   assign mtval_wdata    = r_tval;

endmodule
